// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared DRAM constants, arbiter state encoding and sizing helper
package dram_pkg;

  localparam int DRAM_BANK_WIDTH = 2;
  localparam int DRAM_ROW_WIDTH  = 6;
  localparam int DRAM_COL_WIDTH  = 4;

  localparam logic DRAM_CMD_READ  = 1'b0;
  localparam logic DRAM_CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_FREE = 2'd2,
    ST_WAIT_RD   = 2'd3
  } arb_state_t;

  // Index/counter width that stays at least one bit for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dram_port_arbiter_if.sv
// rtl/dram_port_arbiter_if.sv - requester and controller signal bundle of the DRAM port arbiter
interface dram_port_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int U_ADDR_WIDTH = 12,
  parameter int U_DATA_WIDTH = 2
);

  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_cmd;
  logic [NUM_REQ*U_ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*U_DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]              req_ack;
  logic [NUM_REQ-1:0]              rsp_valid;
  logic [U_DATA_WIDTH-1:0]         rsp_data;
  logic [NUM_REQ-1:0]              rsp_err;

  logic                    ctl_en;
  logic                    ctl_cmd;
  logic [U_ADDR_WIDTH-1:0] ctl_addr;
  logic [U_DATA_WIDTH-1:0] ctl_wdata;
  logic                    ctl_cmd_ack;
  logic                    ctl_busy;
  logic                    ctl_data_valid;
  logic [U_DATA_WIDTH-1:0] ctl_rdata;

  modport slave (
    input  req_valid, req_cmd, req_addr, req_wdata,
    output req_ack, rsp_valid, rsp_data, rsp_err,
    output ctl_en, ctl_cmd, ctl_addr, ctl_wdata,
    input  ctl_cmd_ack, ctl_busy, ctl_data_valid, ctl_rdata
  );

  modport master (
    output req_valid, req_cmd, req_addr, req_wdata,
    input  req_ack, rsp_valid, rsp_data, rsp_err,
    input  ctl_en, ctl_cmd, ctl_addr, ctl_wdata,
    output ctl_cmd_ack, ctl_busy, ctl_data_valid, ctl_rdata
  );

endinterface

// File: rtl/dram_port_arbiter_rr_pick.sv
// rtl/dram_port_arbiter_rr_pick.sv - combinational round-robin priority encoder (rr_pick)
module rr_pick #(
  parameter int N  = 4,
  parameter int GW = 2
) (
  input  logic [N-1:0]  req_valid,
  input  logic [GW-1:0] last_grant,
  output logic [GW-1:0] grant,
  output logic          any
);

  logic [GW-1:0] idx;

  // Search starts just after the previous winner and wraps, so the previous winner is checked last.
  always_comb begin
    any   = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = GW'((int'(last_grant) + i) % N);
      if (!any && req_valid[idx]) begin
        any   = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - round-robin sharing of the dram_controller user port between NUM_REQ requesters
module dram_port_arbiter
  import dram_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int U_ADDR_WIDTH = 12,
  parameter int U_DATA_WIDTH = 2,
  parameter int RD_TIMEOUT   = 64
) (
  input logic                 u_clk,
  input logic                 u_rst,
  dram_port_arbiter_if.slave  bus
);

  localparam int GW = idx_width(NUM_REQ);
  localparam int WW = idx_width(RD_TIMEOUT);

  arb_state_t               state_q, state_d;
  logic [GW-1:0]            last_grant_q, grant_q, pick_idx;
  logic                     pick_any;
  logic                     cmd_q;
  logic [U_ADDR_WIDTH-1:0]  addr_q;
  logic [U_DATA_WIDTH-1:0]  wdata_q, rdata_q;
  logic [NUM_REQ-1:0]       ack_q, rsp_valid_q, rsp_err_q;
  logic [WW-1:0]            wdog_q;
  logic                     rd_expired;
  logic                     ctl_en;

  rr_pick #(.N(NUM_REQ), .GW(GW)) u_rr_pick (
    .req_valid  (bus.req_valid),
    .last_grant (last_grant_q),
    .grant      (pick_idx),
    .any        (pick_any)
  );

  assign rd_expired = (wdog_q == WW'(RD_TIMEOUT - 1));

  always_ff @(posedge u_clk) begin
    if (u_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (pick_any) state_d = ST_ISSUE;
      ST_ISSUE:     if (bus.ctl_cmd_ack)
                      state_d = (cmd_q == DRAM_CMD_WRITE) ? ST_WAIT_FREE : ST_WAIT_RD;
      ST_WAIT_FREE: if (!bus.ctl_busy) state_d = ST_IDLE;
      ST_WAIT_RD:   if (bus.ctl_data_valid || rd_expired) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctl_en = (state_q != ST_IDLE);
  end

  // Requester inputs are only looked at in IDLE; everything after the grant runs off the latched copy.
  always_ff @(posedge u_clk) begin
    if (u_rst) begin
      last_grant_q <= GW'(NUM_REQ - 1);
      grant_q      <= '0;
      cmd_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      ack_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_err_q    <= '0;
      wdog_q       <= '0;
    end else begin
      ack_q       <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q      <= pick_idx;
            last_grant_q <= pick_idx;
            cmd_q        <= bus.req_cmd[pick_idx];
            addr_q       <= bus.req_addr[int'(pick_idx)*U_ADDR_WIDTH +: U_ADDR_WIDTH];
            wdata_q      <= bus.req_wdata[int'(pick_idx)*U_DATA_WIDTH +: U_DATA_WIDTH];
          end
        end
        ST_ISSUE: begin
          if (bus.ctl_cmd_ack) begin
            ack_q[grant_q] <= 1'b1;
            wdog_q         <= '0;
          end
        end
        ST_WAIT_RD: begin
          // Data arriving on the expiry cycle still counts as a good read.
          if (bus.ctl_data_valid) begin
            rdata_q              <= bus.ctl_rdata;
            rsp_valid_q[grant_q] <= 1'b1;
          end else if (rd_expired) begin
            rsp_err_q[grant_q] <= 1'b1;
          end
          if (wdog_q != '1) wdog_q <= wdog_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ctl_en    = ctl_en;
  assign bus.ctl_cmd   = cmd_q;
  assign bus.ctl_addr  = addr_q;
  assign bus.ctl_wdata = wdata_q;
  assign bus.req_ack   = ack_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb/tb_dram_port_arbiter.sv - directed scoreboard bench for dram_port_arbiter with a controller/memory model
module tb_dram_port_arbiter;

  localparam int NR = 4;
  localparam int AW = 12;
  localparam int DW = 2;
  localparam int TO = 64;

  typedef struct packed {
    int          idx;
    logic        cmd;
    logic [11:0] addr;
    logic [1:0]  wdata;
  } cmd_t;

  typedef struct packed {
    int         idx;
    logic [1:0] data;
  } rsp_t;

  logic u_clk = 1'b0;
  logic u_rst;
  always #5 u_clk = ~u_clk;

  dram_port_arbiter_if #(.NUM_REQ(NR), .U_ADDR_WIDTH(AW), .U_DATA_WIDTH(DW)) bus ();

  dram_port_arbiter #(.NUM_REQ(NR), .U_ADDR_WIDTH(AW), .U_DATA_WIDTH(DW), .RD_TIMEOUT(TO)) dut (
    .u_clk (u_clk),
    .u_rst (u_rst),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge u_clk) cyc <= cyc + 1;

  cmd_t exp_cmd[$];
  int   exp_ack[$];
  rsp_t exp_rsp[$];
  int   exp_err[$];

  logic [1:0] mem     [0:4095];
  logic [1:0] ref_mem [0:4095];

  int req_target [NR];
  int ack_seen   [NR];
  int stall_cfg, rd_lat, wr_tail;
  bit withhold;
  int ack_cyc;

  always_comb begin
    for (int k = 0; k < NR; k++) bus.req_valid[k] = (ack_seen[k] < req_target[k]);
  end

  task automatic chk(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Controller + DRAM model: optional busy stall before ack, write busy tail, read latency or withheld data.
  initial begin
    int   m_phase, m_cnt;
    cmd_t m_cap, e;
    m_phase = 0; m_cnt = 0; m_cap = '0;
    for (int a = 0; a < 4096; a++) mem[a] = 2'b00;
    bus.ctl_cmd_ack = 1'b0; bus.ctl_busy = 1'b0; bus.ctl_data_valid = 1'b0; bus.ctl_rdata = '0;
    forever begin
      @(negedge u_clk);
      bus.ctl_cmd_ack    = 1'b0;
      bus.ctl_data_valid = 1'b0;
      if (u_rst) begin
        m_phase = 0;
        bus.ctl_busy = 1'b0;
      end else begin
        if (m_phase == 0 && bus.ctl_en) begin
          m_cap = '{idx: 0, cmd: bus.ctl_cmd, addr: bus.ctl_addr, wdata: bus.ctl_wdata};
          if (exp_cmd.size() == 0) chk("unexpected_cmd", 1, 0);
          else begin
            e = exp_cmd.pop_front();
            chk($sformatf("ctl_cmd_r%0d", e.idx), int'(m_cap.cmd), int'(e.cmd));
            chk($sformatf("ctl_addr_r%0d", e.idx), int'(m_cap.addr), int'(e.addr));
            if (e.cmd) chk($sformatf("ctl_wdata_r%0d", e.idx), int'(m_cap.wdata), int'(e.wdata));
          end
          m_cnt = stall_cfg;
          m_phase = 1;
        end
        if (m_phase == 1) begin
          if (m_cnt > 0) begin
            bus.ctl_busy = 1'b1;
            m_cnt--;
          end else begin
            bus.ctl_busy = 1'b0;
            bus.ctl_cmd_ack = 1'b1;
            chk("ctl_addr_stable", int'(bus.ctl_addr), int'(m_cap.addr));
            if (m_cap.cmd) begin
              mem[m_cap.addr] = m_cap.wdata;
              m_cnt = wr_tail;
              m_phase = 3;
            end else begin
              m_cnt = rd_lat;
              m_phase = 2;
            end
          end
        end else if (m_phase == 2) begin
          if (!bus.ctl_en) m_phase = 0;
          else if (!withhold) begin
            m_cnt--;
            if (m_cnt == 0) begin
              bus.ctl_data_valid = 1'b1;
              bus.ctl_rdata = mem[m_cap.addr];
              m_phase = 0;
            end
          end
        end else if (m_phase == 3) begin
          if (m_cnt > 0) begin
            bus.ctl_busy = 1'b1;
            m_cnt--;
          end else begin
            bus.ctl_busy = 1'b0;
            m_phase = 0;
          end
        end
      end
    end
  end

  // Output monitor: every pulse must match the head of its scoreboard queue.
  initial begin
    int   a, er;
    rsp_t r;
    for (int k = 0; k < NR; k++) ack_seen[k] = 0;
    ack_cyc = 0;
    forever begin
      @(negedge u_clk);
      if (bus.req_ack != '0) begin
        if (exp_ack.size() == 0) chk("unexpected_ack", int'(bus.req_ack), 0);
        else begin
          a = exp_ack.pop_front();
          chk("req_ack_onehot", int'(bus.req_ack), 1 << a);
        end
        for (int k = 0; k < NR; k++) if (bus.req_ack[k]) ack_seen[k]++;
        ack_cyc = cyc;
      end
      if (bus.rsp_valid != '0) begin
        if (exp_rsp.size() == 0) chk("unexpected_rsp", int'(bus.rsp_valid), 0);
        else begin
          r = exp_rsp.pop_front();
          chk("rsp_valid", int'(bus.rsp_valid), 1 << r.idx);
          chk("rsp_data", int'(bus.rsp_data), int'(r.data));
        end
      end
      if (bus.rsp_err != '0) begin
        if (exp_err.size() == 0) chk("unexpected_err", int'(bus.rsp_err), 0);
        else begin
          er = exp_err.pop_front();
          chk("rsp_err", int'(bus.rsp_err), 1 << er);
          chk("err_latency", cyc - ack_cyc, TO);
        end
      end
    end
  end

  task automatic drive(input int k, input logic cmd, input logic [11:0] addr, input logic [1:0] wd, input int n);
    bus.req_cmd[k] = cmd;
    bus.req_addr[k*AW +: AW] = addr;
    bus.req_wdata[k*DW +: DW] = wd;
    req_target[k] = ack_seen[k] + n;
  endtask

  // outcome: 0 = normal completion, 1 = read timeout, 2 = aborted by reset
  task automatic expect_txn(input int k, input logic cmd, input logic [11:0] addr, input logic [1:0] wd, input int outcome);
    exp_cmd.push_back('{idx: k, cmd: cmd, addr: addr, wdata: wd});
    exp_ack.push_back(k);
    if (cmd) ref_mem[addr] = wd;
    else if (outcome == 0) exp_rsp.push_back('{idx: k, data: ref_mem[addr]});
    else if (outcome == 1) exp_err.push_back(k);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!(exp_cmd.size() == 0 && exp_ack.size() == 0 && exp_rsp.size() == 0 && exp_err.size() == 0
             && !bus.ctl_en && bus.req_valid == '0) && n < budget) begin
      @(negedge u_clk);
      n++;
    end
    chk({"done_", tag}, int'(n < budget), 1);
    repeat (3) @(negedge u_clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctl_en"}, int'(bus.ctl_en), 0);
    chk({tag, "_ctl_cmd"}, int'(bus.ctl_cmd), 0);
    chk({tag, "_ctl_addr"}, int'(bus.ctl_addr), 0);
    chk({tag, "_ctl_wdata"}, int'(bus.ctl_wdata), 0);
    chk({tag, "_req_ack"}, int'(bus.req_ack), 0);
    chk({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
    chk({tag, "_rsp_data"}, int'(bus.rsp_data), 0);
    chk({tag, "_rsp_err"}, int'(bus.rsp_err), 0);
  endtask

  initial begin
    int n;
    for (int a = 0; a < 4096; a++) ref_mem[a] = 2'b00;
    for (int k = 0; k < NR; k++) req_target[k] = 0;
    bus.req_cmd = '0; bus.req_addr = '0; bus.req_wdata = '0;
    stall_cfg = 0; rd_lat = 3; wr_tail = 1; withhold = 1'b0;
    u_rst = 1'b1;
    repeat (3) @(negedge u_clk);
    check_all_zero("reset");
    u_rst = 1'b0;
    repeat (2) @(negedge u_clk);

    // single write from requester 2
    drive(2, 1'b1, 12'h3A5, 2'b10, 1);
    expect_txn(2, 1'b1, 12'h3A5, 2'b10, 0);
    wait_done("wr_single", 100);

    // write then read back from requester 1, plus a read of the earlier write
    drive(1, 1'b1, 12'h0C7, 2'b10, 1);
    expect_txn(1, 1'b1, 12'h0C7, 2'b10, 0);
    wait_done("wr_r1", 100);
    drive(1, 1'b0, 12'h0C7, 2'b01, 1);
    expect_txn(1, 1'b0, 12'h0C7, 2'b01, 0);
    wait_done("rd_r1", 100);
    drive(3, 1'b0, 12'h3A5, 2'b00, 1);
    expect_txn(3, 1'b0, 12'h3A5, 2'b00, 0);
    wait_done("rd_r3", 100);

    // all four held for two transactions each after reset: order 0,1,2,3,0,1,2,3
    u_rst = 1'b1;
    repeat (2) @(negedge u_clk);
    u_rst = 1'b0;
    @(negedge u_clk);
    for (int k = 0; k < NR; k++) drive(k, 1'b1, 12'h100 + 12'(k), 2'(k ^ 1), 2);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NR; k++) expect_txn(k, 1'b1, 12'h100 + 12'(k), 2'(k ^ 1), 0);
    wait_done("fairness", 400);

    // data arriving on the last watchdog cycle wins over the timeout
    rd_lat = TO;
    drive(2, 1'b0, 12'h102, 2'b00, 1);
    expect_txn(2, 1'b0, 12'h102, 2'b00, 0);
    wait_done("rd_edge", 200);
    rd_lat = 3;

    // withheld read data: one error pulse, then normal service
    withhold = 1'b1;
    drive(3, 1'b0, 12'h0C7, 2'b00, 1);
    expect_txn(3, 1'b0, 12'h0C7, 2'b00, 1);
    wait_done("rd_timeout", 200);
    withhold = 1'b0;
    drive(3, 1'b0, 12'h0C7, 2'b00, 1);
    expect_txn(3, 1'b0, 12'h0C7, 2'b00, 0);
    wait_done("rd_after_to", 100);

    // refresh stall in ISSUE on a write and on a read
    stall_cfg = 200;
    drive(0, 1'b1, 12'h05A, 2'b11, 1);
    expect_txn(0, 1'b1, 12'h05A, 2'b11, 0);
    wait_done("wr_stall", 400);
    drive(0, 1'b0, 12'h05A, 2'b00, 1);
    expect_txn(0, 1'b0, 12'h05A, 2'b00, 0);
    wait_done("rd_stall", 400);
    stall_cfg = 0;

    // reset while waiting on read data from requester 0
    withhold = 1'b1;
    drive(0, 1'b0, 12'h3A5, 2'b00, 1);
    expect_txn(0, 1'b0, 12'h3A5, 2'b00, 2);
    n = 0;
    while (exp_ack.size() != 0 && n < 100) begin
      @(negedge u_clk);
      n++;
    end
    chk("abort_ack_seen", int'(n < 100), 1);
    repeat (5) @(negedge u_clk);
    chk("abort_in_wait_rd", int'(bus.ctl_en), 1);
    u_rst = 1'b1;
    @(negedge u_clk);
    check_all_zero("mid_reset");
    u_rst = 1'b0;
    withhold = 1'b0;
    repeat (TO + 16) @(negedge u_clk);
    for (int k = 0; k < NR; k++) drive(k, 1'b1, 12'h200 + 12'(k), 2'(k), 1);
    for (int k = 0; k < NR; k++) expect_txn(k, 1'b1, 12'h200 + 12'(k), 2'(k), 0);
    wait_done("post_reset_order", 200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dram_port_arbiter.md
# dram_port_arbiter

Round-robin arbiter that shares the single user port of `dram_controller` between `NUM_REQ` independent requesters, such as a host bus, a DMA engine and a scrubber. It accepts one request at a time, drives the controller's command/address/data inputs, and tracks the controller's handshake through completion. For reads it routes `u_data_o` back to the winning requester, and it guards the read-return phase with a watchdog. It sits between the requester ports and `dram_controller`, clocked by the same `u_clk`.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `U_ADDR_WIDTH`, 12: controller address width, {bank, row, col}.
- `U_DATA_WIDTH`, 2: user data width.
- `RD_TIMEOUT`, 64: maximum cycles allowed from command ack to `u_data_valid`.

Ports (one clock; reset is synchronous and active-high):
- `u_clk` in 1: clock.
- `u_rst` in 1: synchronous, active-high reset.
- `req_valid` in `NUM_REQ`: per-requester request; held until the matching `req_ack`.
- `req_cmd` in `NUM_REQ`: 1 = write, 0 = read.
- `req_addr` in `NUM_REQ*U_ADDR_WIDTH`: flattened; requester k occupies slice `[k*U_ADDR_WIDTH +: U_ADDR_WIDTH]`.
- `req_wdata` in `NUM_REQ*U_DATA_WIDTH`: flattened, same slicing as `req_addr`.
- `req_ack` out `NUM_REQ`: one-cycle pulse when the controller acknowledges that requester's command.
- `rsp_valid` out `NUM_REQ`: one-cycle pulse with read data for that requester.
- `rsp_data` out `U_DATA_WIDTH`: read data; valid only with `rsp_valid`.
- `rsp_err` out `NUM_REQ`: one-cycle pulse on read timeout.
- `ctl_en`, `ctl_cmd`, `ctl_addr`, `ctl_wdata` out 1/1/`U_ADDR_WIDTH`/`U_DATA_WIDTH`: connect to the controller's `u_en`, `u_cmd`, `u_addr`, `u_data_i`.
- `ctl_cmd_ack`, `ctl_busy`, `ctl_data_valid` in 1: connect from the controller's `u_cmd_ack`, `u_busy`, `u_data_valid`.
- `ctl_rdata` in `U_DATA_WIDTH`: connects from the controller's `u_data_o`.

## Operation
States: `IDLE`, `ISSUE`, `WAIT_FREE`, `WAIT_RD`.

- **IDLE**
  - `ctl_en` = 0.
  - If any `req_valid` is set, select the winner by round-robin, starting the search at `last_grant+1` modulo `NUM_REQ`.
  - Register the winner's cmd, addr and wdata into the `ctl_*` outputs, update `last_grant`, and go to ISSUE.
- **ISSUE**
  - `ctl_en` = 1 and `ctl_*` are held stable.
  - On `ctl_cmd_ack`: pulse `req_ack[grant]`.
  - If the command is a write, go to WAIT_FREE. If it is a read, clear the watchdog and go to WAIT_RD.
  - ISSUE has no timeout; refresh may hold `ctl_busy` high for arbitrary time.
- **WAIT_FREE**
  - `ctl_en` = 1.
  - When `ctl_busy` = 0, go to IDLE.
- **WAIT_RD**
  - `ctl_en` = 1 and the watchdog increments each cycle.
  - On `ctl_data_valid`: register `ctl_rdata` into `rsp_data`, pulse `rsp_valid[grant]` on the next cycle, and go to IDLE.
  - If the watchdog reaches `RD_TIMEOUT-1` without `ctl_data_valid`: pulse `rsp_err[grant]` and go to IDLE.
  - If `ctl_data_valid` and timeout expiry occur in the same cycle, valid data wins and no error is raised.
- Requester inputs are sampled only in IDLE. Changes on a granted requester's inputs after the grant are ignored until its `req_ack`.
- Deasserting `req_valid` before `req_ack` is a protocol violation. The latched command still executes.
- Reset values: state = IDLE, `last_grant` = `NUM_REQ-1` (so requester 0 wins first), and all outputs are 0.
- Reset asserted mid-transaction returns to IDLE on the next edge and drops `ctl_en`. No ack, response or error is emitted for the aborted command.

## Timing
- Grant latency: `req_valid` is seen in IDLE at edge n; `ctl_en` = 1 with command outputs valid after edge n.
- `req_ack` is registered: it pulses the cycle after `ctl_cmd_ack` is sampled high.
- Read return: `rsp_valid`/`rsp_data` appear one cycle after `ctl_data_valid` is sampled.
- Turnaround: minimum of one IDLE cycle between transactions, so at most one command is in flight.
- Watchdog width is `$clog2(RD_TIMEOUT)` bits and saturates. `RD_TIMEOUT` = 1 therefore errors on the first WAIT_RD cycle unless data arrives that cycle.
- Fairness: each active requester is served at most `NUM_REQ-1` transactions after raising `req_valid`.

## Structure
- The state encoding and the `DRAM_CMD_READ`/`DRAM_CMD_WRITE` constants (0/1) go in the shared `dram_pkg`, alongside the controller's address-field widths.
- One sub-module, `rr_pick`: combinational round-robin priority encoder.
  - Inputs: `req_valid` and `last_grant`.
  - Outputs: grant index and `any`.
  - It is reusable for the bank scheduler.
- FSM, registers and watchdog live in the top level.

## Test plan
- Single write, requester 2, addr 12'h3A5, data 2'b10 → controller sees `ctl_cmd` = 1 and addr 3A5; `req_ack[2]` pulses once; `rsp_valid` never fires.
- Write then read to the same address from requester 1 → `rsp_valid[1]` with `rsp_data` = 2'b10, matching a scoreboard memory model of `dram_controller` + `dram`.
- All 4 requesters asserted continuously for 8 transactions after reset → grant order 0,1,2,3,0,1,2,3.
- Controller model withholds `ctl_data_valid` for 64 cycles after a read ack, with `RD_TIMEOUT` = 64 → `rsp_err[grant]` pulses once, `rsp_valid` stays 0, and the FSM returns to IDLE; a following request is served normally.
- Refresh stall: `ctl_busy` held high for 200 cycles during ISSUE → no error, and the command is issued after busy falls.
- `u_rst` asserted in WAIT_RD → all outputs 0 on the next cycle, no pulses emitted, and requester 0 is granted first after reset.
